// File: rtl/dcache_bus_bridge_if.sv
// rtl/dcache_bus_bridge_if.sv - word-wide request/grant/response data bus
//
// Signals:
//   bus_req    master->slave  request valid, held until grant
//   bus_we     master->slave  write enable
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  lane-replicated store data
//   bus_be     master->slave  byte enables
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  read data valid or write acknowledge
//   bus_rdata  slave->master  read data
interface dcache_bus_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [3:0]            bus_be;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/dcache_bus_bridge.sv
// rtl/dcache_bus_bridge.sv - Mem-stage data request to variable-latency bus bridge
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   Mem_DcacheEN      request valid (load or store)
//   Mem_DcacheRd      1 = load, 0 = store
//   Mem_DcacheWidth   00 byte, 01 half, 10/11 word
//   Mem_DcacheAddr    byte address
//   Mem_DcacheSign    1 = sign-extend load result
//   EXMem_Rs2Data     store data, LSB-aligned
//   Dcache_DataRd     formatted load result, valid in the completion cycle
//   Dcache_StallReq   stall request to the pipeline controller
//   Dcache_Err        one-cycle flag: misaligned access or bus timeout
//   bus               master side of the data bus
module dcache_bus_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic                  Mem_DcacheSign,
    input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
    output logic [DATA_WIDTH-1:0] Dcache_DataRd,
    output logic                  Dcache_StallReq,
    output logic                  Dcache_Err,
    dcache_bus_bridge_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t state, state_next;

    logic [7:0]            wait_cnt;
    logic                  timeout_hit;

    // Load attributes captured at request time; the pipeline inputs are not
    // relied upon once the transaction has been launched.
    logic                  ld_load;
    logic [1:0]            ld_width;
    logic                  ld_sign;
    logic [1:0]            ld_off;

    logic                  misaligned;
    logic [3:0]            fmt_be;
    logic [DATA_WIDTH-1:0] fmt_wdata;
    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] rd_fmt;

    // Store lane steering and byte enables; loads use the same enables.
    always_comb begin
        fmt_be     = 4'b1111;
        fmt_wdata  = EXMem_Rs2Data;
        misaligned = 1'b0;
        case (Mem_DcacheWidth)
            2'b00: begin
                fmt_be    = 4'b0001 << Mem_DcacheAddr[1:0];
                fmt_wdata = {4{EXMem_Rs2Data[7:0]}};
            end
            2'b01: begin
                fmt_be     = Mem_DcacheAddr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata  = {2{EXMem_Rs2Data[15:0]}};
                misaligned = Mem_DcacheAddr[0];
            end
            default: begin
                fmt_be     = 4'b1111;
                fmt_wdata  = EXMem_Rs2Data;
                misaligned = |Mem_DcacheAddr[1:0];
            end
        endcase
    end

    // Load alignment and extension from the captured lane offset.
    always_comb begin
        rd_shifted = bus.bus_rdata >> {ld_off, 3'b000};
        rd_fmt     = rd_shifted;
        case (ld_width)
            2'b00:   rd_fmt = {{24{ld_sign & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_fmt = {{16{ld_sign & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_fmt = rd_shifted;
        endcase
    end

    assign timeout_hit = (wait_cnt == LAST_WAIT);

    // DONE drops the stall so the pipeline advances exactly once.
    assign Dcache_StallReq = ((state == IDLE) && Mem_DcacheEN) ||
                             (state == REQ) || (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Mem_DcacheEN) begin
                    state_next = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.bus_rvalid || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // EN is deliberately ignored: the same instruction is still
                // presented for this one cycle.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= 4'b0000;
            Dcache_DataRd <= '0;
            Dcache_Err    <= 1'b0;
            wait_cnt      <= 8'd0;
            ld_load       <= 1'b0;
            ld_width      <= 2'b00;
            ld_sign       <= 1'b0;
            ld_off        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    Dcache_DataRd <= '0;
                    Dcache_Err    <= 1'b0;
                    if (Mem_DcacheEN) begin
                        if (misaligned) begin
                            Dcache_Err <= 1'b1;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= ~Mem_DcacheRd;
                            bus.bus_addr  <= {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
                            bus.bus_wdata <= fmt_wdata;
                            bus.bus_be    <= fmt_be;
                            ld_load       <= Mem_DcacheRd;
                            ld_width      <= Mem_DcacheWidth;
                            ld_sign       <= Mem_DcacheSign;
                            ld_off        <= Mem_DcacheAddr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        wait_cnt    <= 8'd0;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle wins over the error.
                    if (bus.bus_rvalid) begin
                        Dcache_DataRd <= ld_load ? rd_fmt : '0;
                    end else if (timeout_hit) begin
                        Dcache_Err    <= 1'b1;
                        Dcache_DataRd <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    Dcache_DataRd <= '0;
                    Dcache_Err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_bus_bridge.sv
// tb/tb_dcache_bus_bridge.sv - randomized self-checking bench for dcache_bus_bridge
module tb_dcache_bus_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  width = 2'b00;
    logic [31:0] addr = 32'd0;
    logic        sign = 1'b0;
    logic [31:0] rs2 = 32'd0;
    logic [31:0] data_rd;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    dcache_bus_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    dcache_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Mem_DcacheEN    (en),
        .Mem_DcacheRd    (rd),
        .Mem_DcacheWidth (width),
        .Mem_DcacheAddr  (addr),
        .Mem_DcacheSign  (sign),
        .EXMem_Rs2Data   (rs2),
        .Dcache_DataRd   (data_rd),
        .Dcache_StallReq (stall),
        .Dcache_Err      (err),
        .bus             (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_data"}, data_rd, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_req"}, {31'd0, bus_if.bus_req}, 32'd0);
    endtask

    // Reference: expected outcome computed from the access rules, then the bench
    // plays the bus slave with the requested grant/response delays.
    task automatic run_txn(input logic t_rd, input logic [1:0] t_w, input logic [31:0] t_a,
                           input logic t_sign, input logic [31:0] t_rs2,
                           input int gnt_dly, input int rv_dly, input logic [31:0] t_rdata);
        logic [1:0]  off;
        logic        mis, tmo;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_data;
        logic [7:0]  b;
        logic [15:0] h;
        int e_stall, stall_cnt, req_cyc, wait_cyc, cyc;
        bit granted, done;

        off = t_a[1:0];
        mis = (t_w == 2'b01 && t_a[0]) || (t_w[1] && off != 2'b00);
        tmo = (rv_dly >= TO);
        if (t_w == 2'b00) begin
            e_be    = 4'(1 << off);
            e_wdata = {t_rs2[7:0], t_rs2[7:0], t_rs2[7:0], t_rs2[7:0]};
        end else if (t_w == 2'b01) begin
            e_be    = off[1] ? 4'b1100 : 4'b0011;
            e_wdata = {t_rs2[15:0], t_rs2[15:0]};
        end else begin
            e_be    = 4'b1111;
            e_wdata = t_rs2;
        end
        b = t_rdata[8*off +: 8];
        h = off[1] ? t_rdata[31:16] : t_rdata[15:0];
        if (mis || tmo || !t_rd)      e_data = 32'd0;
        else if (t_w == 2'b00)        e_data = (t_sign && b[7])  ? (32'hFFFFFF00 | b) : {24'd0, b};
        else if (t_w == 2'b01)        e_data = (t_sign && h[15]) ? (32'hFFFF0000 | h) : {16'd0, h};
        else                          e_data = t_rdata;
        e_stall = mis ? 1 : (1 + (gnt_dly + 1) + (tmo ? TO : rv_dly + 1));

        en = 1'b1; rd = t_rd; width = t_w; addr = t_a; sign = t_sign; rs2 = t_rs2;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
        stall_cnt = 0; req_cyc = 0; wait_cyc = 0; cyc = 0; granted = 0; done = 0;
        while (!done) begin
            #1;
            bus_if.bus_gnt = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_rdata = $urandom;
            if (!stall) begin
                check("stall_cycles", 32'(stall_cnt), 32'(e_stall));
                check("done_data", data_rd, e_data);
                check("done_err", {31'd0, err}, {31'd0, mis | tmo});
                done = 1;
            end else begin
                stall_cnt++;
                if (bus_if.bus_req) begin
                    check("req_aligned_only", {31'd0, bus_if.bus_req}, {31'd0, !mis});
                    check("bus_addr", bus_if.bus_addr, t_a & 32'hFFFFFFFC);
                    check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, !t_rd});
                    check("bus_be", {28'd0, bus_if.bus_be}, {28'd0, e_be});
                    if (!t_rd) check("bus_wdata", bus_if.bus_wdata, e_wdata);
                    if (req_cyc == gnt_dly) begin
                        bus_if.bus_gnt = 1'b1;
                        granted = 1;
                    end
                    req_cyc++;
                end else if (granted) begin
                    if (wait_cyc == rv_dly) begin
                        bus_if.bus_rvalid = 1'b1;
                        bus_if.bus_rdata = t_rdata;
                    end
                    wait_cyc++;
                end
            end
            cyc++;
            if (cyc > 100) begin
                check("txn_cycle_bound", 32'(cyc), 32'd100);
                done = 1;
            end
            @(negedge clk);
        end
        en = 1'b0;
        bus_if.bus_gnt = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        #1;
        check_quiet("idle_after");
    endtask

    initial begin
        logic [1:0]  w;
        logic [31:0] a;
        int          guard;

        bus_if.bus_gnt = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata = 32'd0;
        @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_addr", bus_if.bus_addr, 32'd0);
        check("reset_be", {28'd0, bus_if.bus_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 2'b10, 32'h100, 1'b0, 32'h0, 0, 1, 32'h8899AABB);
        run_txn(1'b1, 2'b00, 32'h103, 1'b1, 32'h0, 0, 0, 32'h80112233);
        run_txn(1'b1, 2'b00, 32'h103, 1'b0, 32'h0, 1, 2, 32'h80112233);
        run_txn(1'b0, 2'b01, 32'h202, 1'b0, 32'h1234ABCD, 0, 0, 32'h0);
        run_txn(1'b1, 2'b10, 32'h101, 1'b0, 32'h0, 0, 0, 32'h0);
        run_txn(1'b0, 2'b00, 32'h301, 1'b0, 32'h000000A5, 5, 1, 32'h0);
        run_txn(1'b1, 2'b01, 32'h402, 1'b1, 32'h0, 0, TO - 1, 32'h8001F00D);
        run_txn(1'b1, 2'b10, 32'h500, 1'b0, 32'h0, 1, 9, 32'hDEADBEEF);

        // Response arriving after a timeout, while idle, must be ignored.
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        #1;
        check_quiet("late_rvalid");

        for (int i = 0; i < 60; i++) begin
            w = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (w == 2'b01) a[0] = 1'b0;
                else if (w[1]) a[1:0] = 2'b00;
            end
            run_txn(1'($urandom), w, a, 1'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
        end

        // Reset in WAIT drops the transaction; a later response is ignored.
        @(negedge clk);
        en = 1'b1; rd = 1'b1; width = 2'b10; addr = 32'h300; sign = 1'b0;
        guard = 0;
        #1;
        while (!bus_if.bus_req && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("rst_req_seen", {31'd0, bus_if.bus_req}, 32'd1);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        #1;
        check("rst_wait_stall", {31'd0, stall}, 32'd1);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        check("rst_mid_we", {31'd0, bus_if.bus_we}, 32'd0);
        check("rst_mid_addr", bus_if.bus_addr, 32'd0);
        check("rst_mid_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_mid_be", {28'd0, bus_if.bus_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        #1;
        check_quiet("rst_late_rvalid");
        @(negedge clk);
        #1;
        check_quiet("rst_settled");

        run_txn(1'b1, 2'b01, 32'h600, 1'b0, 32'h0, 2, 0, 32'h1234F0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
